// File: rtl/prime_pkg.sv
// rtl/prime_pkg.sv - shared types and widths for the prime sieve reader
package prime_pkg;

    localparam int RANGE_DEFAULT = 10000;
    localparam int CHUNK_DEFAULT = 16;
    localparam int NUM_W_DEFAULT = $clog2(RANGE_DEFAULT + 1);

    // Raw encodings kept as plain constants so older code can compare against them.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_EMIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        SCAN = ST_SCAN,
        EMIT = ST_EMIT,
        DONE = ST_DONE
    } state_e;

    function automatic int num_w(input int range);
        return $clog2(range + 1);
    endfunction

endpackage

// File: rtl/prime_reader_if.sv
// rtl/prime_reader_if.sv - prime output stream (value, valid, ready)
//  master: drives prime_out/out_valid, samples out_ready
//  slave : samples prime_out/out_valid, drives out_ready
interface prime_reader_if #(
    parameter int NUM_W = prime_pkg::NUM_W_DEFAULT
);
    logic [NUM_W-1:0] prime_out;
    logic             out_valid;
    logic             out_ready;

    modport master (output prime_out, output out_valid, input out_ready);
    modport slave  (input prime_out, input out_valid, output out_ready);
endinterface

// File: rtl/prime_lsb_enc.sv
// rtl/prime_lsb_enc.sv - combinational lowest-set-bit encoder
//  in  : CHUNK-bit window
//  hit : any bit of in set
//  idx : position of the lowest set bit (0 when no hit)
module prime_lsb_enc #(
    parameter int CHUNK = 16,
    parameter int IDX_W = (CHUNK > 1) ? $clog2(CHUNK) : 1
) (
    input  logic [CHUNK-1:0] in,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        hit = |in;
        idx = '0;
        // Walk downward so the lowest set bit is the last one written.
        for (int j = CHUNK - 1; j >= 0; j--) begin
            if (in[j]) begin
                idx = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/prime_reader.sv
// rtl/prime_reader.sv - streams the primes marked in a sieve bitmap, ascending
//  clk, rst         : clock, synchronous active-high reset
//  start            : begins a scan when idle
//  bitmap[RANGE]    : bit i set <=> i+1 is prime; stable from start to done
//  out_if (master)  : prime_out / out_valid / out_ready stream
//  busy             : scanning or emitting
//  done             : one-cycle pulse at end of scan
//  prime_count      : primes handed off this scan (only with PRIME_READER_COUNT_EN)
module prime_reader
    import prime_pkg::*;
#(
    parameter int RANGE = RANGE_DEFAULT,
    parameter int CHUNK = CHUNK_DEFAULT,
    parameter int NUM_W = $clog2(RANGE + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [RANGE-1:0] bitmap,
    prime_reader_if.master   out_if,
    output logic             busy,
    output logic             done
`ifdef PRIME_READER_COUNT_EN
    ,
    output logic [NUM_W-1:0] prime_count
`endif
);

    localparam int CW     = (CHUNK > 1) ? $clog2(CHUNK) : 1;
    localparam int NCHUNK = (RANGE + CHUNK - 1) / CHUNK;
    // One spare chunk of zeros keeps the window select in bounds even when
    // ptr has advanced to RANGE after the final hand-off.
    localparam int PAD_W  = (NCHUNK + 1) * CHUNK;

    localparam logic [NUM_W-1:0] RANGE_N = NUM_W'(RANGE);
    localparam logic [NUM_W:0]   RANGE_X = (NUM_W + 1)'(RANGE);

    state_e           state_q, state_d;
    logic [NUM_W-1:0] ptr_q, ptr_d;
    logic [NUM_W-1:0] prime_q, prime_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [PAD_W-1:0] bitmap_pad;
    logic [NUM_W-1:0] base;
    logic [CW-1:0]    offset;
    logic [CHUNK-1:0] window;
    logic [CHUNK-1:0] window_m;
    logic             enc_hit;
    logic [CW-1:0]    enc_idx;
    logic [NUM_W-1:0] hit_idx;
    logic [NUM_W:0]   next_boundary;
    logic             handshake;

    // Bits at or above RANGE read as zero, so a partial last chunk never hits.
    assign bitmap_pad = {{(PAD_W - RANGE){1'b0}}, bitmap};
    assign base       = ptr_q & ~NUM_W'(CHUNK - 1);
    assign offset     = ptr_q[CW-1:0];

    always_comb begin
        window = bitmap_pad[base +: CHUNK];
        // Drop everything below ptr: those numbers were already emitted or skipped.
        for (int j = 0; j < CHUNK; j++) begin
            window_m[j] = window[j] && (CW'(j) >= offset);
        end
    end

    prime_lsb_enc #(
        .CHUNK (CHUNK),
        .IDX_W (CW)
    ) u_lsb_enc (
        .in  (window_m),
        .hit (enc_hit),
        .idx (enc_idx)
    );

    assign hit_idx       = base + NUM_W'(enc_idx);
    // One bit wider so a boundary past RANGE cannot wrap back into range.
    assign next_boundary = {1'b0, base} + (NUM_W + 1)'(CHUNK);
    assign handshake     = valid_q && out_if.out_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        prime_d = prime_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    // Number 1 (bit 0) is never a prime, so begin at bit 1.
                    ptr_d   = NUM_W'(1);
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (enc_hit) begin
                    prime_d = hit_idx + NUM_W'(1);
                    valid_d = 1'b1;
                    state_d = EMIT;
                end else if (next_boundary >= RANGE_X) begin
                    state_d = DONE;
                end else begin
                    ptr_d = next_boundary[NUM_W-1:0];
                end
            end
            EMIT: begin
                if (handshake) begin
                    valid_d = 1'b0;
                    // prime_q is idx+1, i.e. the bit just after the emitted one.
                    ptr_d   = prime_q;
                    state_d = (prime_q >= RANGE_N) ? DONE : SCAN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == SCAN) || (state_d == EMIT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            prime_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            prime_q <= prime_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out_if.prime_out = prime_q;
    assign out_if.out_valid = valid_q;
    assign busy             = busy_q;
    assign done             = done_q;

`ifdef PRIME_READER_COUNT_EN
    logic [NUM_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (state_q == IDLE && start) begin
            count_d = '0;
        end else if (handshake) begin
            count_d = count_q + NUM_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign prime_count = count_q;
`endif

endmodule
